// File: rtl/frame_loader.sv
// Ping-pong frame buffer: two 1024x8 banks fed from a pixel stream and read
// by a classifier. A small FSM launches one classification per full bank.
module frame_loader #(
    parameter int QW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic          go,
    input  logic          lenet_ready,
    input  logic [3:0]    digit_in,
    input  logic          cena_src,
    input  logic [9:0]    aa_src,
    output logic [QW-1:0] qa_src,
    output logic [3:0]    digit_out,
    output logic          digit_valid,
    output logic [15:0]   frame_cnt
);

    // state  | meaning
    // IDLE   | waiting for the read bank to become full
    // LAUNCH | go asserted for one cycle
    // RUN    | classifier working on rd_bank, waiting for lenet_ready
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [9:0]    wr_cnt_q, wr_cnt_d;
    logic [1:0]    full_q, full_d;
    logic          go_q, go_d;
    logic [QW-1:0] qa_q, qa_d;
    logic [3:0]    digit_q, digit_d;
    logic          dv_q, dv_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    logic [7:0]    bank_mem [2][1024];
    logic [7:0]    rd_byte;
    logic          accept;
    logic          frame_done;
    logic          release_frame;

    assign s_ready       = ~full_q[wr_bank_q];
    assign accept        = s_valid & s_ready;
    assign frame_done    = accept && (wr_cnt_q == 10'd1023);
    assign release_frame = (state_q == ST_RUN) && lenet_ready;
    assign rd_byte       = bank_mem[rd_bank_q][aa_src];

    always_comb begin
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_cnt_d    = wr_cnt_q;
        full_d      = full_q;
        frame_cnt_d = frame_cnt_q;
        digit_d     = digit_q;
        dv_d        = 1'b0;
        qa_d        = qa_q;

        if (accept) begin
            wr_cnt_d = wr_cnt_q + 10'd1;
        end
        // A completing write and a releasing read always hit different banks,
        // since a write needs its bank empty and a release needs its bank full.
        if (frame_done) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        if (release_frame) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            frame_cnt_d       = frame_cnt_q + 16'd1;
            digit_d           = digit_in;
            dv_d              = 1'b1;
        end
        if (!cena_src) begin
            qa_d = QW'(rd_byte);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (full_q[rd_bank_q]) state_d = ST_LAUNCH;
            ST_LAUNCH: state_d = ST_RUN;
            ST_RUN:    if (lenet_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        go_d = (state_d == ST_LAUNCH);
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q     <= ST_IDLE;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= 10'd0;
            full_q      <= 2'b00;
            go_q        <= 1'b0;
            qa_q        <= '0;
            digit_q     <= 4'd0;
            dv_q        <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            full_q      <= full_d;
            go_q        <= go_d;
            qa_q        <= qa_d;
            digit_q     <= digit_d;
            dv_q        <= dv_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Bank storage has no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            bank_mem[wr_bank_q][wr_cnt_q] <= s_data;
        end
    end

    assign go          = go_q;
    assign qa_src      = qa_q;
    assign digit_out   = digit_q;
    assign digit_valid = dv_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader: streaming, ping-pong hand-off, reads and reset.
module tb_frame_loader;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        go;
    logic        lenet_ready;
    logic [3:0]  digit_in;
    logic        cena_src;
    logic [9:0]  aa_src;
    logic [31:0] qa_src;
    logic [3:0]  digit_out;
    logic        digit_valid;
    logic [15:0] frame_cnt;

    frame_loader #(.QW(32)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .go(go), .lenet_ready(lenet_ready),
        .digit_in(digit_in), .cena_src(cena_src), .aa_src(aa_src),
        .qa_src(qa_src), .digit_out(digit_out), .digit_valid(digit_valid),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cnt = 0, last_acc = 0;
    int go_cnt = 0, last_go = 0, go_wide = 0;
    int dv_cnt = 0, dv_wide = 0;
    logic go_prev = 1'b0, dv_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rstn) begin
            if (s_valid && s_ready) begin
                acc_cnt++;
                last_acc = cyc;
            end
            if (go) begin
                go_cnt++;
                last_go = cyc;
                if (go_prev) go_wide++;
            end
            if (digit_valid) begin
                dv_cnt++;
                if (dv_prev) dv_wide++;
            end
        end
        go_prev = go;
        dv_prev = digit_valid;
    end

    typedef struct {
        logic        cena;
        logic [9:0]  aa;
        logic [31:0] exp;
        string       name;
    } rd_vec_t;

    rd_vec_t rd_tab [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers one pixel and waits (bounded) for acceptance; stalls counts wait cycles.
    task automatic send_pixel(input logic [7:0] d, inout int stalls);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 5000) begin
            tick(1);
            n++;
        end
        if (!s_ready) chk("send_timeout", 32'(s_ready), 32'd1);
        stalls += n;
        tick(1);
        s_valid = 1'b0;
    endtask

    task automatic rd(input logic cena, input logic [9:0] a, input logic [31:0] exp, input string nm);
        cena_src = cena;
        aa_src   = a;
        tick(1);
        chk(nm, qa_src, exp);
        cena_src = 1'b1;
    endtask

    task automatic release_digit(input logic [3:0] d, input logic [15:0] exp_cnt);
        lenet_ready = 1'b1;
        digit_in    = d;
        tick(1);
        lenet_ready = 1'b0;
        chk("rel_digit_out", 32'(digit_out), 32'(d));
        chk("rel_digit_valid", 32'(digit_valid), 32'd1);
        chk("rel_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        chk("rel_s_ready", 32'(s_ready), 32'd1);
        tick(1);
        chk("rel_dv_drop", 32'(digit_valid), 32'd0);
        chk("rel_go_next", 32'(go), 32'd1);
        tick(1);
        chk("rel_go_one", 32'(go), 32'd0);
    endtask

    initial begin
        int stalls;
        int acc_snap;
        int go_snap;

        rd_tab[0] = '{1'b0, 10'd0,    32'd0,   "rd_a0"};
        rd_tab[1] = '{1'b0, 10'd255,  32'd255, "rd_a255"};
        rd_tab[2] = '{1'b0, 10'd300,  32'd44,  "rd_a300"};
        rd_tab[3] = '{1'b0, 10'd1023, 32'd255, "rd_a1023"};
        rd_tab[4] = '{1'b1, 10'd5,    32'd255, "rd_hold"};
        rd_tab[5] = '{1'b0, 10'd77,   32'd77,  "rd_a77"};

        rstn = 1'b1; s_valid = 1'b0; s_data = 8'd0; lenet_ready = 1'b0;
        digit_in = 4'd0; cena_src = 1'b1; aa_src = 10'd0;
        tick(3);
        chk("rst_go", 32'(go), 32'd0);
        chk("rst_qa", qa_src, 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        rstn = 1'b0;
        tick(2);
        chk("post_rst_no_go", 32'(go_cnt), 32'd0);

        // lenet_ready while idle is ignored
        lenet_ready = 1'b1; digit_in = 4'd9;
        tick(1);
        lenet_ready = 1'b0;
        chk("idle_rel_dv", 32'(digit_valid), 32'd0);
        chk("idle_rel_digit", 32'(digit_out), 32'd0);
        chk("idle_rel_cnt", 32'(frame_cnt), 32'd0);

        // frame 0: pixel i = i[7:0]
        stalls = 0;
        for (int i = 0; i < 1024; i++) send_pixel(8'(i), stalls);
        chk("f0_no_stall", 32'(stalls), 32'd0);
        chk("f0_accepts", 32'(acc_cnt), 32'd1024);
        tick(4);
        chk("f0_go_count", 32'(go_cnt), 32'd1);
        chk("f0_go_gap", 32'(last_go - last_acc), 32'd2);
        chk("f0_s_ready", 32'(s_ready), 32'd1);

        for (int i = 0; i < 6; i++) rd(rd_tab[i].cena, rd_tab[i].aa, rd_tab[i].exp, rd_tab[i].name);

        // frame 1: all 0xAA while frame 0 is being read
        stalls = 0;
        for (int i = 0; i < 1024; i++) send_pixel(8'hAA, stalls);
        chk("f1_accepts", 32'(acc_cnt), 32'd2048);
        tick(2);
        chk("both_full_s_ready", 32'(s_ready), 32'd0);
        chk("both_full_no_go", 32'(go_cnt), 32'd1);
        for (int i = 0; i < 6; i++) rd(rd_tab[i].cena, rd_tab[i].aa, rd_tab[i].exp, {rd_tab[i].name, "_after_aa"});

        // third frame offered while both banks are full
        acc_snap = acc_cnt;
        s_valid = 1'b1; s_data = 8'h55;
        tick(20);
        s_valid = 1'b0;
        chk("blocked_accepts", 32'(acc_cnt - acc_snap), 32'd0);

        release_digit(4'd7, 16'd1);
        chk("go_bank1_count", 32'(go_cnt), 32'd2);
        rd(1'b0, 10'd10, 32'hAA, "rd_bank1");
        rd(1'b0, 10'd1023, 32'hAA, "rd_bank1_end");

        // frame 2 into bank 0: pixel i = (3*i)[7:0]
        for (int i = 0; i < 1024; i++) send_pixel(8'(3 * i), stalls);
        tick(2);
        chk("f2_s_ready", 32'(s_ready), 32'd0);
        rd(1'b0, 10'd10, 32'hAA, "rd_bank1_kept");
        release_digit(4'd3, 16'd2);
        chk("go_f2_count", 32'(go_cnt), 32'd3);
        rd(1'b0, 10'd0, 32'd0, "rd_f2_a0");
        rd(1'b0, 10'd1, 32'd3, "rd_f2_a1");
        rd(1'b0, 10'd1023, 32'd253, "rd_f2_a1023");

        // reset mid-frame
        for (int i = 0; i < 500; i++) send_pixel(8'h11, stalls);
        rstn = 1'b1;
        #1;
        chk("mid_rst_go", 32'(go), 32'd0);
        chk("mid_rst_qa", qa_src, 32'd0);
        chk("mid_rst_digit", 32'(digit_out), 32'd0);
        chk("mid_rst_dv", 32'(digit_valid), 32'd0);
        chk("mid_rst_cnt", 32'(frame_cnt), 32'd0);
        chk("mid_rst_s_ready", 32'(s_ready), 32'd1);
        tick(3);
        rstn = 1'b0;
        go_snap = go_cnt;
        stalls = 0;
        for (int i = 0; i < 1024; i++) send_pixel(8'(255 - i), stalls);
        chk("nf_no_stall", 32'(stalls), 32'd0);
        tick(4);
        chk("nf_go_count", 32'(go_cnt - go_snap), 32'd1);
        chk("nf_go_gap", 32'(last_go - last_acc), 32'd2);
        rd(1'b0, 10'd0, 32'd255, "rd_nf_a0");
        rd(1'b0, 10'd499, 32'd12, "rd_nf_a499");
        rd(1'b0, 10'd1023, 32'd0, "rd_nf_a1023");

        chk("go_width", 32'(go_wide), 32'd0);
        chk("dv_width", 32'(dv_wide), 32'd0);
        chk("dv_total", 32'(dv_cnt), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_loader.md
FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 QW, default 32, width of qa_src; pixels are zero-extended to QW bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous and active-high (asserted = 1).
REQ-004 s_valid  input  1  upstream pixel valid.
REQ-005 s_data  input  8  pixel byte, raster order, 32x32 = 1024 per frame.
REQ-006 s_ready  output  1  loader can accept a pixel this cycle.
REQ-007 go  output  1  one-cycle start pulse to the classifier.
REQ-008 lenet_ready  input  1  classifier done pulse; digit_in is valid in the same cycle.
REQ-009 digit_in  input  4  classifier result.
REQ-010 cena_src  input  1  classifier read enable, active-low.
REQ-011 aa_src  input  10  classifier read address.
REQ-012 qa_src  output  QW  registered read data.
REQ-013 digit_out  output  4  last captured result.
REQ-014 digit_valid  output  1  one-cycle pulse when digit_out updates.
REQ-015 frame_cnt  output  16  frames completed since reset.

Function
REQ-016 The loader SHALL hold two 1024x8 banks (ping-pong), with a write pointer wr_bank, a read pointer rd_bank and per-bank full flags full[1:0].
REQ-017 A pixel SHALL be accepted when s_valid and s_ready are both 1; s_ready SHALL be !full[wr_bank], combinational.
REQ-018 An accepted pixel SHALL be written to bank[wr_bank][wr_cnt], and wr_cnt (10 bits) SHALL increment.
REQ-019 On accepting the pixel with wr_cnt = 1023, the loader SHALL set full[wr_bank] to 1, toggle wr_bank, and wrap wr_cnt to 0, all in the next state.
REQ-020 The read FSM SHALL have three states: IDLE, LAUNCH, RUN.
- IDLE -> LAUNCH when full[rd_bank] = 1.
- LAUNCH -> RUN unconditionally.
- RUN -> IDLE on lenet_ready.
REQ-021 go SHALL be registered and equal 1 exactly during LAUNCH, giving exactly one cycle per frame.
REQ-022 If the last pixel is accepted in cycle N, then full is set at N+1, and go SHALL be high in cycle N+2 when the FSM is IDLE.
REQ-023 On lenet_ready in RUN, the loader SHALL do the following in the next state:
- clear full[rd_bank];
- toggle rd_bank;
- increment frame_cnt (wrapping at 16 bits);
- load digit_out with digit_in;
- pulse digit_valid for one cycle.
REQ-024 lenet_ready in IDLE or LAUNCH SHALL be ignored: no state change and no digit_valid.
REQ-025 When cena_src = 0, qa_src SHALL load the zero-extended bank[rd_bank][aa_src] on the next edge (1-cycle latency); when cena_src = 1, qa_src SHALL hold its value.
REQ-026 Reads SHALL always target rd_bank; a write to bank wr_bank SHALL never alter data being read from a full rd_bank.
REQ-027 Setting full[wr_bank] and clearing full[rd_bank] in the same cycle SHALL both take effect; different banks never conflict.
REQ-028 When both banks are full, s_ready SHALL stay 0 until the RUN frame releases its bank; the next frame's go SHALL then follow in the first cycle the FSM re-enters IDLE->LAUNCH.
REQ-029 Pixels offered while s_ready = 0 SHALL NOT be written or counted.

Reset
REQ-030 While rstn = 1, the loader SHALL asynchronously clear:
- wr_bank, rd_bank, wr_cnt and full[1:0];
- FSM to IDLE;
- go, qa_src, digit_out, digit_valid and frame_cnt to 0.
REQ-031 Bank contents SHALL NOT be required to reset.
REQ-032 Reset mid-frame SHALL discard the partial frame; after release, s_ready SHALL be 1 and loading SHALL restart at wr_cnt = 0, bank 0.
REQ-033 go SHALL NOT pulse within 2 cycles of reset release.

Verification
REQ-034 Stream 1024 bytes, pixel i = i[7:0], with s_valid held high -> s_ready stays 1 throughout, and go pulses once exactly 2 cycles after the last accept.
REQ-035 After go, read aa_src = 0, 255, 300, 1023 with cena_src = 0 -> qa_src = 0, 255, 44, 255 one cycle later; with cena_src = 1, qa_src holds.
REQ-036 Stream 3 frames back-to-back with lenet_ready withheld -> frames 0 and 1 accepted, s_ready = 0 after 2048 accepts; then lenet_ready with digit_in = 7 -> digit_out = 7, digit_valid is a 1-cycle pulse, frame_cnt = 1, s_ready returns to 1, and go pulses for bank 1.
REQ-037 Frame 1 filled with all 0xAA while frame 0 is being read -> reads of bank 0 return the frame-0 data unchanged.
REQ-038 Assert rstn after 500 pixels -> all outputs 0; after release, 1024 new pixels produce go, and reads return only the new data.
REQ-039 lenet_ready pulsed while the FSM is IDLE -> frame_cnt, digit_out and digit_valid unchanged.
